// File: rtl/branch_table_ctrl.sv
// Port arbiter for the 64x2 branch-direction SRAM: reset-time init sweep, fetch
// predict reads, and saturating read-modify-write counter updates from a small FIFO.
module branch_table_ctrl #(
   parameter int         IDX_W    = 6,
   parameter int         UQ_DEPTH = 4,
   parameter logic [1:0] INIT_CTR = 2'b01
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pred_req,
   input  logic [IDX_W-1:0] pred_idx,
   output logic             pred_ready,
   output logic             pred_valid,
   output logic             pred_taken,
   output logic [1:0]       pred_ctr,
   input  logic             upd_valid,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken,
   output logic             upd_ready,
   output logic             init_done,
   output logic             sram_csb,
   output logic             sram_web,
   output logic [IDX_W-1:0] sram_addr,
   output logic [1:0]       sram_din,
   input  logic [1:0]       sram_dout
);

   localparam int               QP_W     = $clog2(UQ_DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};
   localparam logic [1:0]       ST_RST   = 2'd0;
   localparam logic [1:0]       ST_INIT  = 2'd1;
   localparam logic [1:0]       ST_RUN   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] sweep_q, sweep_d;
   logic             wr_phase_q, wr_phase_d;
   logic             pred_valid_q, pred_valid_d;
   logic [QP_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [IDX_W:0]   q_mem_q [UQ_DEPTH];
   logic [IDX_W:0]   q_mem_d [UQ_DEPTH];

   logic             run_s, q_full_s, q_empty_s, head_tk_s;
   logic [IDX_W-1:0] head_idx_s;

   function automatic logic [1:0] sat_ctr(input logic [1:0] ctr, input logic taken);
      if (taken) begin
         return (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
      end else begin
         return (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
      end
   endfunction

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign q_empty_s  = (wr_ptr_q == rd_ptr_q);
   assign q_full_s   = (wr_ptr_q[QP_W] != rd_ptr_q[QP_W]) &&
                       (wr_ptr_q[QP_W-1:0] == rd_ptr_q[QP_W-1:0]);
   assign head_idx_s = q_mem_q[rd_ptr_q[QP_W-1:0]][IDX_W:1];
   assign head_tk_s  = q_mem_q[rd_ptr_q[QP_W-1:0]][0];

   assign run_s      = (state_q == ST_RUN);
   assign init_done  = run_s;
   assign upd_ready  = run_s & ~q_full_s;
   assign pred_ready = run_s & ~wr_phase_q & ~q_full_s;
   assign pred_valid = pred_valid_q;
   assign pred_ctr   = pred_valid_q ? sram_dout : 2'b00;
   assign pred_taken = pred_valid_q & sram_dout[1];

   // Next-state, SRAM command and queue bookkeeping.
   always_comb begin
      state_d      = state_q;
      sweep_d      = sweep_q;
      wr_phase_d   = wr_phase_q;
      pred_valid_d = 1'b0;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      q_mem_d      = q_mem_q;
      sram_csb     = 1'b1;
      sram_web     = 1'b1;
      sram_addr    = '0;
      sram_din     = 2'b00;
      case (state_q)
         ST_RST: begin
            state_d = ST_INIT;
         end
         ST_INIT: begin
            sram_csb  = 1'b0;
            sram_web  = 1'b0;
            sram_addr = sweep_q;
            sram_din  = INIT_CTR;
            sweep_d   = sweep_q + IDX_W'(1);
            if (sweep_q == LAST_IDX) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_INIT;
            end
         end
         ST_RUN: begin
            if (wr_phase_q) begin
               sram_csb   = 1'b0;
               sram_web   = 1'b0;
               sram_addr  = head_idx_s;
               sram_din   = sat_ctr(sram_dout, head_tk_s);
               rd_ptr_d   = rd_ptr_q + (QP_W+1)'(1);
               wr_phase_d = 1'b0;
            end else if (q_full_s || (!pred_req && !q_empty_s)) begin
               // A full queue outranks fetch so updates cannot starve forever.
               sram_csb   = 1'b0;
               sram_addr  = head_idx_s;
               wr_phase_d = 1'b1;
            end else if (pred_req) begin
               sram_csb     = 1'b0;
               sram_addr    = pred_idx;
               pred_valid_d = 1'b1;
            end else begin
               sram_csb = 1'b1;
            end
         end
         default: begin
            state_d = ST_RST;
         end
      endcase
      if (upd_valid && upd_ready) begin
         q_mem_d[wr_ptr_q[QP_W-1:0]] = {upd_idx, upd_taken};
         wr_ptr_d = wr_ptr_q + (QP_W+1)'(1);
      end else begin
         wr_ptr_d = wr_ptr_d;
      end
   end

   // State, sweep counter, RMW phase, predict-valid and update FIFO registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_RST;
         sweep_q      <= '0;
         wr_phase_q   <= 1'b0;
         pred_valid_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         q_mem_q      <= '{default: '0};
      end else begin
         state_q      <= state_d;
         sweep_q      <= sweep_d;
         wr_phase_q   <= wr_phase_d;
         pred_valid_q <= pred_valid_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         q_mem_q      <= q_mem_d;
      end
   end

endmodule

// File: tb/tb_branch_table_ctrl.sv
// Bench for branch_table_ctrl: behavioural SRAM, a table/queue reference model of
// the arbitration rules, directed scenarios and a randomized traffic phase.
module tb_branch_table_ctrl;

   localparam int IDX_W = 6;
   localparam int DEPTH = 64;
   localparam int UQ    = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             pred_req = 1'b0;
   logic [IDX_W-1:0] pred_idx = '0;
   logic             pred_ready, pred_valid, pred_taken;
   logic [1:0]       pred_ctr;
   logic             upd_valid = 1'b0;
   logic [IDX_W-1:0] upd_idx = '0;
   logic             upd_taken = 1'b0;
   logic             upd_ready, init_done;
   logic             sram_csb, sram_web;
   logic [IDX_W-1:0] sram_addr;
   logic [1:0]       sram_din;
   logic [1:0]       sram_dout;

   int n_checks = 0;
   int n_errors = 0;

   branch_table_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .pred_req(pred_req), .pred_idx(pred_idx), .pred_ready(pred_ready),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ctr(pred_ctr),
      .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
      .upd_ready(upd_ready), .init_done(init_done),
      .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
      .sram_din(sram_din), .sram_dout(sram_dout)
   );

   always #5 clk = ~clk;

   // Single-port SRAM: commands captured at the edge, read data valid next cycle.
   logic [1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (!sram_csb) begin
         if (!sram_web) mem[sram_addr] <= sram_din;
         else           sram_dout      <= mem[sram_addr];
      end
   end

   // Reference model: expected table contents, pending updates, RMW in flight.
   int cyc;
   int tab [DEPTH];
   int q_idx [$];
   bit q_tk [$];
   bit wr;
   bit pv;
   int pv_val;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int sat(input int c, input bit t);
      if (t) return (c == 3) ? 3 : c + 1;
      return (c == 0) ? 0 : c - 1;
   endfunction

   task automatic model_reset();
      cyc = 0; wr = 1'b0; pv = 1'b0; pv_val = 0;
      q_idx.delete(); q_tk.delete();
      foreach (tab[i]) tab[i] = 1;
   endtask

   // One clock cycle: called just after a falling edge with inputs already set.
   task automatic cycle();
      bit run, ini, full, acc;
      int ecsb, eweb, eaddr, edin, kind;
      #1;
      run = (cyc >= 65);
      ini = (cyc >= 1 && cyc <= 64);
      full = (q_idx.size() == UQ);
      ecsb = 1; eweb = 1; eaddr = 0; edin = 0; kind = 0;
      if (ini) begin
         ecsb = 0; eweb = 0; eaddr = cyc - 1; edin = 1; kind = 4;
      end else if (run) begin
         if (wr) begin
            ecsb = 0; eweb = 0; eaddr = q_idx[0]; edin = sat(tab[q_idx[0]], q_tk[0]); kind = 3;
         end else if (full || (!pred_req && q_idx.size() > 0)) begin
            ecsb = 0; eaddr = q_idx[0]; kind = 2;
         end else if (pred_req) begin
            ecsb = 0; eaddr = int'(pred_idx); kind = 1;
         end
      end
      check_eq("sram_csb", sram_csb, ecsb);
      if (ecsb == 0) begin
         check_eq("sram_web", sram_web, eweb);
         check_eq("sram_addr", sram_addr, eaddr);
         if (eweb == 0) check_eq("sram_din", sram_din, edin);
      end
      check_eq("pred_ready", pred_ready, run && !wr && !full);
      check_eq("upd_ready", upd_ready, run && !full);
      check_eq("init_done", init_done, run);
      check_eq("pred_valid", pred_valid, pv);
      check_eq("pred_ctr", pred_ctr, pv ? pv_val : 0);
      check_eq("pred_taken", pred_taken, pv ? ((pv_val >> 1) & 1) : 0);
      acc = (kind == 1);
      @(posedge clk);
      if (kind == 3) begin
         tab[q_idx[0]] = edin;
         void'(q_idx.pop_front()); void'(q_tk.pop_front());
         wr = 1'b0;
      end else if (kind == 2) begin
         wr = 1'b1;
      end
      if (upd_valid && run && !full) begin
         q_idx.push_back(int'(upd_idx)); q_tk.push_back(upd_taken);
      end
      pv = acc;
      if (acc) pv_val = tab[int'(pred_idx)];
      if (cyc < 1000) cyc++;
      @(negedge clk);
   endtask

   task automatic reset_checks();
      check_eq("rst_pred_ready", pred_ready, 0);
      check_eq("rst_pred_valid", pred_valid, 0);
      check_eq("rst_pred_taken", pred_taken, 0);
      check_eq("rst_pred_ctr", pred_ctr, 0);
      check_eq("rst_upd_ready", upd_ready, 0);
      check_eq("rst_init_done", init_done, 0);
      check_eq("rst_sram_csb", sram_csb, 1);
      check_eq("rst_sram_web", sram_web, 1);
      check_eq("rst_sram_addr", sram_addr, 0);
      check_eq("rst_sram_din", sram_din, 0);
   endtask

   // Asynchronous reset asserted mid-cycle, before the next rising edge.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1 reset_checks();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic idle(input int n);
      pred_req = 1'b0; upd_valid = 1'b0;
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic drain();
      pred_req = 1'b0; upd_valid = 1'b0;
      for (int k = 0; k < 40 && (q_idx.size() > 0 || wr); k++) cycle();
      check_eq("drain_timeout", q_idx.size() + int'(wr), 0);
   endtask

   task automatic push(input int idx, input bit tk);
      upd_valid = 1'b1; upd_idx = idx[IDX_W-1:0]; upd_taken = tk;
      cycle();
      upd_valid = 1'b0;
   endtask

   task automatic predict(input int idx, output int ctr);
      drain();
      pred_req = 1'b1; pred_idx = idx[IDX_W-1:0];
      cycle();
      pred_req = 1'b0;
      #1;
      ctr = int'(pred_ctr);
      check_eq("predict_valid", pred_valid, 1);
      cycle();
   endtask

   initial begin
      int c;
      model_reset();
      @(negedge clk);
      #1 reset_checks();
      @(negedge clk);
      rst_n = 1'b1;

      // Init sweep, then a predict of an untouched entry.
      idle(70);
      predict(5, c);
      check_eq("init_idx5_ctr", c, 1);

      // Saturation up and down on idx 7.
      push(7, 1'b1); push(7, 1'b1);
      predict(7, c); check_eq("idx7_up", c, 3);
      push(7, 1'b1);
      predict(7, c); check_eq("idx7_sat_hi", c, 3);
      push(7, 1'b0); push(7, 1'b0); push(7, 1'b0);
      predict(7, c); check_eq("idx7_down", c, 0);
      push(7, 1'b0);
      predict(7, c); check_eq("idx7_sat_lo", c, 0);

      // Continuous predicts with one pending update, then release fetch.
      pred_req = 1'b1; pred_idx = 6'd9;
      push(9, 1'b1);
      for (int k = 0; k < 10; k++) begin
         pred_idx = 6'($urandom_range(0, DEPTH - 1));
         cycle();
      end
      check_eq("update_pending", q_idx.size(), 1);
      idle(4);
      predict(9, c); check_eq("idx9_after_hold", c, 2);

      // Fill the queue under predict pressure; fifth push is dropped.
      pred_req = 1'b1; pred_idx = 6'd1;
      upd_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         upd_idx = 6'(10 + k);
         upd_taken = (k % 2 == 0);
         cycle();
      end
      upd_valid = 1'b0;
      for (int k = 0; k < 12; k++) cycle();
      drain();
      predict(10, c); check_eq("full_idx10", c, 2);
      predict(11, c); check_eq("full_idx11", c, 0);
      predict(12, c); check_eq("full_idx12", c, 2);
      predict(13, c); check_eq("full_idx13", c, 0);
      predict(14, c); check_eq("dropped_idx14", c, 1);

      // Back-to-back updates to the same index.
      push(3, 1'b1); push(3, 1'b1); push(3, 1'b0);
      predict(3, c); check_eq("idx3_final", c, 2);

      // Randomized traffic against the model.
      for (int k = 0; k < 1500; k++) begin
         pred_req  = ($urandom_range(0, 1) == 1);
         pred_idx  = 6'($urandom_range(0, DEPTH - 1));
         upd_valid = ($urandom_range(0, 9) < 3);
         upd_idx   = 6'($urandom_range(0, 15));
         upd_taken = $urandom_range(0, 1);
         cycle();
      end
      drain();

      // Reset during the write phase of an RMW.
      push(20, 1'b1);
      for (int k = 0; k < 10 && !wr; k++) cycle();
      check_eq("rmw_timeout", wr, 1);
      do_reset();
      for (int k = 0; k < 31; k++) cycle();
      // Reset while the sweep writes index 30.
      check_eq("init_idx30_addr", sram_addr, 30);
      do_reset();
      idle(70);
      for (int i = 0; i < DEPTH; i++) begin
         predict(i, c);
         check_eq("post_reset_ctr", c, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/branch_table_ctrl.md
# branch_table_ctrl

Controller that owns the single-port, 64-entry x 2-bit branch table SRAM (`mp_ooo_branch_table`) and shares its one RW port between fetch-stage predict lookups and commit-stage counter updates. It initializes every entry after reset, performs saturating read-modify-write updates from a small update queue, and returns taken/not-taken predictions one cycle after the lookup is accepted. It sits between the fetch/branch-commit logic and the SRAM macro.

## Interface
- `IDX_W`, 6: table index width; depth is 2^IDX_W.
- `UQ_DEPTH`, 4: update queue entries (power of two).
- `INIT_CTR`, 2'b01: counter value written to every entry during init (weakly not-taken).

- `clk`  in  1  clock; the SRAM's `clk0` is driven from the same clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pred_req`  in  1  lookup request.
- `pred_idx`  in  IDX_W  lookup index.
- `pred_ready`  out  1  lookup accepted this cycle when `pred_req & pred_ready`.
- `pred_valid`  out  1  prediction result valid.
- `pred_taken`  out  1  predicted direction (counter bit 1).
- `pred_ctr`  out  2  raw counter value.
- `upd_valid`  in  1  update push.
- `upd_idx`  in  IDX_W  index to update.
- `upd_taken`  in  1  resolved direction.
- `upd_ready`  out  1  queue not full; the push happens when `upd_valid & upd_ready`.
- `init_done`  out  1  init sweep complete.
- `sram_csb`, `sram_web`  out  1  chip select and write enable, both active-low.
- `sram_addr`  out  IDX_W  SRAM address.
- `sram_din`  out  2  SRAM write data.
- `sram_dout`  in  2  SRAM read data.

## Operation
- The SRAM captures csb/web/addr/din at a clock edge.
  - A write lands in the array at the following edge.
  - Read data is valid the cycle after the command is issued.
- SRAM command outputs are driven combinationally from controller state and the queue head.
- States:
  - RST: the reset state. `sram_csb=1`. It moves to INIT unconditionally after one cycle.
  - INIT: the sweep counter `i` runs 0..2^IDX_W-1. Each cycle the block issues a write of `INIT_CTR` to address `i`. After the last index it goes to RUN.
  - RUN: normal arbitration. There is no exit except reset.
- RUN port priority per cycle (highest first):
  1. The write phase of an in-flight read-modify-write (RMW).
  2. An update read, when the queue is full.
  3. A predict read, when `pred_req` is asserted.
  4. An update read, when the queue is non-empty.
  5. Idle, with `sram_csb=1`.
- `pred_ready = RUN & !wr_phase & !q_full`. It must not depend on `pred_req`.
- Predict:
  - An accepted request issues a read of `pred_idx`.
  - The registered `pred_valid` is 1 in the next cycle.
  - In that cycle `pred_ctr = sram_dout` and `pred_taken = sram_dout[1]`.
  - When `pred_valid=0`, `pred_ctr` and `pred_taken` are 0.
- Update RMW:
  - Read cycle: issue a read of the queue-head index and set `wr_phase`. The entry is not popped.
  - Write cycle: issue a write to the same index with `din = sat(sram_dout, taken)`, pop the queue, and clear `wr_phase`.
  - `sat`: if taken, `ctr==3 ? 3 : ctr+1`; if not taken, `ctr==0 ? 0 : ctr-1`.
  - The write is always performed, even when the counter is already saturated.
- Queue:
  - FIFO of {idx, taken}, with `upd_ready = RUN & !q_full`.
  - A push while full is ignored. There is no full-bypass.
  - A push and a pop in the same cycle are both allowed when not full.
- Hazards:
  - Back-to-back updates to the same index need no forwarding. The port rule guarantees at least one cycle between an RMW read and the next read, so the array is already written.
  - A predict read that overlaps a queued, not-yet-applied update returns the old value. This is acceptable.
- Reset mid-operation:
  - Asynchronous reset clears the queue, `wr_phase`, and the sweep counter, and returns to RST.
  - An interrupted RMW is dropped.
  - The init sweep restarts from index 0.

## Timing
- Reset values: `pred_ready=0`, `pred_valid=0`, `pred_taken=0`, `pred_ctr=0`, `upd_ready=0`, `init_done=0`, `sram_csb=1`, `sram_web=1`, `sram_addr=0`, `sram_din=0`.
- Let cycle 0 be the first cycle after `rst_n` rises.
  - Cycle 0: RST.
  - Cycles 1..64: INIT writes indices 0..63.
  - From cycle 65: RUN, with `init_done=1`, `pred_ready=1` and `upd_ready=1`.
- Predict latency: 1 cycle from acceptance to `pred_valid`. Throughput is 1 per cycle when no RMW is active.
- Update: 2 port cycles per entry. A queue entry is applied, and visible to reads issued 2 cycles later, once it reaches the head.

## Test plan
- Reset, then idle 70 cycles. Required:
  - 64 writes of 2'b01 to addresses 0..63 in cycles 1..64.
  - `init_done` rises in cycle 65.
  - A predict of index 5 returns `pred_ctr=1`, `pred_taken=0`.
- Push update (idx 7, taken) twice, wait, then predict idx 7. Required: `pred_ctr=3`, `pred_taken=1`. Further taken updates leave it at 3. Three not-taken updates give 0, and it stays at 0.
- Hold `pred_req=1` continuously while pushing 1 update. Required:
  - Predicts win while the queue is not full.
  - The RMW read and write then occupy 2 consecutive cycles with `pred_ready=0` during the write phase.
  - `pred_valid` is never asserted for a cycle with no accepted request.
- With `pred_req` held, push 4 updates. Required:
  - `upd_ready=0` once 4 are queued.
  - `pred_ready=0` while full, with update reads taking priority.
  - A 5th push while full is dropped.
  - All 4 counters end correct.
- Alternate updates to idx 3: taken, taken, not-taken, back to back. Required: final `pred_ctr=2` (from 1 -> 2 -> 3 -> 2), with no lost update.
- Assert `rst_n=0` during the write phase of an RMW and during init index 30. Required:
  - Outputs go immediately to their reset values.
  - The queue is empty.
  - The sweep restarts at index 0 and all entries read 2'b01.
